// File: rtl/uart_pid_cmd_rx_if.sv
// PID gain bus: three registered gains plus write/error strobes.
interface uart_pid_cmd_rx_if #(
    parameter int GAIN_WIDTH = 16
);
    logic [GAIN_WIDTH-1:0] k_p;
    logic [GAIN_WIDTH-1:0] k_i;
    logic [GAIN_WIDTH-1:0] k_d;
    logic                  gain_upd;
    logic                  frame_err;

    modport master (
        output k_p, k_i, k_d, gain_upd, frame_err
    );

    modport slave (
        input k_p, k_i, k_d, gain_upd, frame_err
    );
endinterface

// File: rtl/uart_pid_cmd_rx.sv
// UART 8N1 receiver with framed command parser writing PID gains.
module uart_pid_cmd_rx #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int GAIN_WIDTH   = 16,
    parameter int INIT_KP      = 960,
    parameter int INIT_KI      = 0,
    parameter int INIT_KD      = 107,
    parameter int TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_rx,
    uart_pid_cmd_rx_if.master gains
);
    localparam int BW   = $clog2(CLKS_PER_BIT + 1);
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [BW-1:0] HALF_M1 = BW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [2:0] {
        WAIT_HDR, GET_CMD, GET_DHI, GET_DLO, GET_CHK
    } ps_state_t;

    logic rx_s1, rx_s2, rx_prev;
    rx_state_t rx_state, rx_state_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic [7:0] sh_q, sh_d;
    logic byte_vld, stop_err, start_det;

    ps_state_t ps, ps_d;
    logic [7:0] cmd_q, cmd_d, dhi_q, dhi_d, dlo_q, dlo_d;
    logic [TW-1:0] to_cnt, to_d;
    logic [GAIN_WIDTH-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
    logic upd_q, upd_d, err_q, err_d;

    logic [15:0] word;
    logic [GAIN_WIDTH-1:0] wval;
    assign word = {dhi_q, dlo_q};

    generate
        if (GAIN_WIDTH <= 16) begin : g_trunc
            assign wval = word[GAIN_WIDTH-1:0];
        end else begin : g_ext
            assign wval = {{(GAIN_WIDTH-16){1'b0}}, word};
        end
    endgenerate

    // Bit receiver: start detection on the synchronized falling edge only
    always_comb begin
        rx_state_d = rx_state;
        bit_cnt_d  = bit_cnt;
        bit_idx_d  = bit_idx;
        sh_d       = sh_q;
        byte_vld   = 1'b0;
        stop_err   = 1'b0;
        start_det  = 1'b0;
        case (rx_state)
            IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_d = START;
                    bit_cnt_d  = '0;
                    start_det  = 1'b1;
                end
            end
            START: begin
                if (bit_cnt == HALF_M1) begin
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    rx_state_d = rx_s2 ? IDLE : DATA;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_d = '0;
                    sh_d      = {rx_s2, sh_q[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rx_state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
            default: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_d  = '0;
                    rx_state_d = IDLE;
                    byte_vld   = rx_s2;
                    stop_err   = !rx_s2;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        ps_d  = ps;
        cmd_d = cmd_q;
        dhi_d = dhi_q;
        dlo_d = dlo_q;
        to_d  = to_cnt;
        kp_d  = kp_q;
        ki_d  = ki_q;
        kd_d  = kd_q;
        upd_d = 1'b0;
        err_d = 1'b0;
        if (stop_err) begin
            ps_d  = WAIT_HDR;
            err_d = 1'b1;
        end else if (byte_vld) begin
            case (ps)
                WAIT_HDR: if (sh_q == 8'hA5) ps_d = GET_CMD;
                GET_CMD: begin cmd_d = sh_q; ps_d = GET_DHI; end
                GET_DHI: begin dhi_d = sh_q; ps_d = GET_DLO; end
                GET_DLO: begin dlo_d = sh_q; ps_d = GET_CHK; end
                default: begin
                    ps_d = WAIT_HDR;
                    if (sh_q != (cmd_q ^ dhi_q ^ dlo_q)) begin
                        err_d = 1'b1;
                    end else begin
                        upd_d = 1'b1;
                        case (cmd_q)
                            8'h01: kp_d = wval;
                            8'h02: ki_d = wval;
                            8'h03: kd_d = wval;
                            default: begin
                                upd_d = 1'b0;
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end else if (start_det || ps == WAIT_HDR) begin
            to_d = '0;
        end else if (rx_state == IDLE) begin
            if (to_cnt == TO_M1) begin
                to_d  = '0;
                ps_d  = WAIT_HDR;
                err_d = 1'b1;
            end else begin
                to_d = to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            sh_q     <= '0;
            ps       <= WAIT_HDR;
            cmd_q    <= '0;
            dhi_q    <= '0;
            dlo_q    <= '0;
            to_cnt   <= '0;
            kp_q     <= GAIN_WIDTH'(INIT_KP);
            ki_q     <= GAIN_WIDTH'(INIT_KI);
            kd_q     <= GAIN_WIDTH'(INIT_KD);
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rx_s1    <= serial_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_d;
            bit_cnt  <= bit_cnt_d;
            bit_idx  <= bit_idx_d;
            sh_q     <= sh_d;
            ps       <= ps_d;
            cmd_q    <= cmd_d;
            dhi_q    <= dhi_d;
            dlo_q    <= dlo_d;
            to_cnt   <= to_d;
            kp_q     <= kp_d;
            ki_q     <= ki_d;
            kd_q     <= kd_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign gains.k_p       = kp_q;
    assign gains.k_i       = ki_q;
    assign gains.k_d       = kd_q;
    assign gains.gain_upd  = upd_q;
    assign gains.frame_err = err_q;
endmodule
